// File: rtl/vga_fb_scanout.sv
// vga_fb_scanout
// Generates 640x480@60 raster timing from clk_vga and scans a 1-bpp framebuffer in
// which every stored pixel covers a DIV x DIV screen block. The pipeline has four steps:
//   stage 0  h/v counters and row base address
//   stage 1  framebuffer address and read strobe
//   stage 2  read data returns from memory, with sync/blank delayed alongside it
//   stage 3  registered colour, sync and vblank outputs
// Colour and sync leave the block 3 cycles after their counter value.
// frame_start is decoded directly from stage 0.
module vga_fb_scanout #(
    parameter int         H_VIS  = 640,
    parameter int         H_FP   = 16,
    parameter int         H_SYNC = 96,
    parameter int         H_BP   = 48,
    parameter int         V_VIS  = 480,
    parameter int         V_FP   = 10,
    parameter int         V_SYNC = 2,
    parameter int         V_BP   = 33,
    parameter int         DIV    = 4,
    parameter logic [7:0] FG_RGB = 8'hFF,
    parameter logic [7:0] BG_RGB = 8'h00
) (
    input  logic        clk_vga,
    input  logic        reset,
    input  logic        enable,
    output logic [14:0] fb_addr,
    output logic        fb_rd_en,
    input  logic        fb_rd_data,
    output logic        hsync,
    output logic        vsync,
    output logic [1:0]  red,
    output logic [2:0]  green,
    output logic [2:0]  blue,
    output logic        vblank,
    output logic        frame_start
);

    localparam int         DIV_LOG2   = $clog2(DIV);
    localparam logic [9:0] H_LAST     = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] V_LAST     = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] H_VIS_END  = 10'(H_VIS);
    localparam logic [9:0] V_VIS_END  = 10'(V_VIS);
    localparam logic [9:0] HS_FIRST   = 10'(H_VIS + H_FP);
    localparam logic [9:0] HS_LAST    = 10'(H_VIS + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST   = 10'(V_VIS + V_FP);
    localparam logic [9:0] VS_LAST    = 10'(V_VIS + V_FP + V_SYNC - 1);
    localparam logic [9:0] LAST_LINE  = 10'(V_VIS - 1);
    localparam logic [9:0] DIV_MASK   = 10'(DIV - 1);
    localparam logic [14:0] ROW_STRIDE = 15'(H_VIS / DIV);

    // Stage 0 state. run goes high one cycle after enable, so the first issued
    // counter value after an idle period is always (0,0).
    logic        run;
    logic [9:0]  h_cnt;
    logic [9:0]  v_cnt;
    logic [14:0] row_base;

    // Stage 0 decode
    logic       h_wrap;
    logic       v_wrap;
    logic       visible0;
    logic       hs0;
    logic       vs0;
    logic       vb0;
    logic       row_step;
    logic [9:0] col;

    // Stage 1 / stage 2 sideband (valid, visible, syncs, blank)
    logic v1, vis1, hs1, vs1, vb1;
    logic v2, vis2, hs2, vs2, vb2;

    // Decode counter position into visibility, sync windows and row advance.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path through
        // the conditionals leaves it unassigned and infers a latch.
        h_wrap   = 1'b0;
        v_wrap   = 1'b0;
        visible0 = 1'b0;
        hs0      = 1'b1;
        vs0      = 1'b1;
        vb0      = 1'b0;
        row_step = 1'b0;
        col      = h_cnt >> DIV_LOG2;

        if (h_cnt == H_LAST) h_wrap = 1'b1;
        if (v_cnt == V_LAST) v_wrap = 1'b1;
        if (h_cnt < H_VIS_END && v_cnt < V_VIS_END) visible0 = 1'b1;
        if (h_cnt >= HS_FIRST && h_cnt <= HS_LAST) hs0 = 1'b0;
        if (v_cnt >= VS_FIRST && v_cnt <= VS_LAST) vs0 = 1'b0;
        if (v_cnt >= V_VIS_END) vb0 = 1'b1;
        // Move to the next framebuffer row after the last replicated line of a row.
        if (h_wrap && ((v_cnt & DIV_MASK) == DIV_MASK) && v_cnt < LAST_LINE)
            row_step = 1'b1;
    end

    assign frame_start = run && (h_cnt == 10'd0) && (v_cnt == 10'd0);

    // Stage 0: raster counters and running row base (replaces a row*width multiply).
    always_ff @(posedge clk_vga or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values of the others, whatever the statement order.
        if (!reset) begin
            run      <= 1'b0;
            h_cnt    <= 10'd0;
            v_cnt    <= 10'd0;
            row_base <= 15'd0;
        end else if (!enable) begin
            run      <= 1'b0;
            h_cnt    <= 10'd0;
            v_cnt    <= 10'd0;
            row_base <= 15'd0;
        end else begin
            run <= 1'b1;
            if (run) begin
                h_cnt <= h_wrap ? 10'd0 : h_cnt + 10'd1;
                if (h_wrap)
                    v_cnt <= v_wrap ? 10'd0 : v_cnt + 10'd1;
                if (h_wrap && v_wrap)
                    row_base <= 15'd0;
                else if (row_step)
                    row_base <= row_base + ROW_STRIDE;
            end
        end
    end

    // Stage 1: framebuffer address and read strobe; the address holds during blanking.
    always_ff @(posedge clk_vga or negedge reset) begin
        if (!reset) begin
            fb_addr  <= 15'd0;
            fb_rd_en <= 1'b0;
            v1       <= 1'b0;
            vis1     <= 1'b0;
            hs1      <= 1'b1;
            vs1      <= 1'b1;
            vb1      <= 1'b0;
        end else if (!enable) begin
            fb_addr  <= 15'd0;
            fb_rd_en <= 1'b0;
            v1       <= 1'b0;
            vis1     <= 1'b0;
            hs1      <= 1'b1;
            vs1      <= 1'b1;
            vb1      <= 1'b0;
        end else begin
            v1       <= run;
            fb_rd_en <= run && visible0;
            if (run) begin
                vis1 <= visible0;
                hs1  <= hs0;
                vs1  <= vs0;
                vb1  <= vb0;
                if (visible0)
                    fb_addr <= row_base + 15'(col);
            end
        end
    end

    // Stage 2: sideband travels with the memory read, whose data arrives next cycle.
    always_ff @(posedge clk_vga or negedge reset) begin
        if (!reset) begin
            v2   <= 1'b0;
            vis2 <= 1'b0;
            hs2  <= 1'b1;
            vs2  <= 1'b1;
            vb2  <= 1'b0;
        end else if (!enable) begin
            v2   <= 1'b0;
            vis2 <= 1'b0;
            hs2  <= 1'b1;
            vs2  <= 1'b1;
            vb2  <= 1'b0;
        end else begin
            v2   <= v1;
            vis2 <= vis1;
            hs2  <= hs1;
            vs2  <= vs1;
            vb2  <= vb1;
        end
    end

    // Stage 3: registered outputs; fb_rd_data is the returned pixel for stage 2.
    always_ff @(posedge clk_vga or negedge reset) begin
        if (!reset) begin
            hsync              <= 1'b1;
            vsync              <= 1'b1;
            vblank             <= 1'b0;
            {red, green, blue} <= 8'h00;
        end else if (!enable) begin
            hsync              <= 1'b1;
            vsync              <= 1'b1;
            vblank             <= 1'b0;
            {red, green, blue} <= 8'h00;
        end else begin
            hsync  <= v2 ? hs2 : 1'b1;
            vsync  <= v2 ? vs2 : 1'b1;
            vblank <= v2 && vb2;
            if (v2 && vis2)
                {red, green, blue} <= fb_rd_data ? FG_RGB : BG_RGB;
            else
                {red, green, blue} <= 8'h00;
        end
    end

endmodule
